// File: rtl/line_sequencer_if.sv
// Handshake bundle linking the line sequencer to its input/output line RAMs
// and to the Controller/Datapath core.
interface line_sequencer_if #(
  parameter int WIDTH  = 25,
  parameter int ADDR_W = 6
);
  logic              go;
  logic [ADDR_W-1:0] in_addr;
  logic [WIDTH-1:0]  in_data;
  logic              core_start;
  logic [WIDTH-1:0]  core_line;
  logic [ADDR_W-1:0] core_count;
  logic              core_done;
  logic [WIDTH-1:0]  core_result;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [WIDTH-1:0]  out_data;
  logic              busy;
  logic              all_done;
  logic              timeout_err;
  logic [ADDR_W:0]   lines_done;

  // Sequencer side.
  modport master (
    input  go, in_data, core_done, core_result,
    output in_addr, core_start, core_line, core_count,
           out_we, out_addr, out_data, busy, all_done, timeout_err, lines_done
  );

  // RAM/core/controller side.
  modport slave (
    output go, in_data, core_done, core_result,
    input  in_addr, core_start, core_line, core_count,
           out_we, out_addr, out_data, busy, all_done, timeout_err, lines_done
  );
endinterface

// File: rtl/line_sequencer.sv
// Handshake-driven line sequencer: walks the input line RAM, hands each line
// to the core with a start pulse, waits for done (or the per-line watchdog)
// and writes the result to the output line RAM. All outputs are registered.
module line_sequencer #(
  parameter int LINES   = 64,
  parameter int WIDTH   = 25,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  line_sequencer_if.master seq_if
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_READ   = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_STORE  = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  localparam logic [TO_W-1:0]   TIMEOUT_C = TO_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_C    = ADDR_W'(LINES - 1);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [TO_W-1:0]   ONE_T     = TO_W'(1);
  localparam logic [ADDR_W:0]   ONE_L     = (ADDR_W + 1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              start_run_s;
  logic              timeout_hit_s;

  logic [ADDR_W-1:0] in_addr_q;
  logic [WIDTH-1:0]  core_line_q;
  logic [ADDR_W-1:0] core_count_q;
  logic              core_start_q;
  logic [TO_W-1:0]   wd_q;
  logic              out_we_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [ADDR_W:0]   lines_done_q;
  logic              busy_q;
  logic              all_done_q;
  logic              timeout_err_q;

  // Next-state selection plus the run-start and watchdog-expiry strobes.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    start_run_s   = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (seq_if.go) begin
          state_d     = S_FETCH;
          index_d     = {ADDR_W{1'b0}};
          start_run_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: state_d = S_READ;
      S_READ:  state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // done wins over an expiring watchdog in the same cycle
        if (seq_if.core_done) begin
          state_d = S_STORE;
        end else if (wd_q == TIMEOUT_C) begin
          state_d       = S_STORE;
          timeout_hit_s = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_STORE: begin
        // the last line ends the run; the index never wraps to 0
        if (index_q == LAST_C) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_FETCH;
          index_d = index_q + ONE_A;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, line index and watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      index_q <= {ADDR_W{1'b0}};
      wd_q    <= {TO_W{1'b0}};
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      // the watchdog counts WAIT cycles from 0; it expires when it reads TIMEOUT
      if (state_q == S_ISSUE) begin
        wd_q <= {TO_W{1'b0}};
      end else if (state_q == S_WAIT && state_d == S_WAIT) begin
        wd_q <= wd_q + ONE_T;
      end else begin
        wd_q <= wd_q;
      end
    end
  end

  // Input-RAM address and the line/index presented to the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_addr_q    <= {ADDR_W{1'b0}};
      core_line_q  <= {WIDTH{1'b0}};
      core_count_q <= {ADDR_W{1'b0}};
      core_start_q <= 1'b0;
    end else begin
      if (state_d == S_FETCH) begin
        in_addr_q <= index_d;
      end else begin
        in_addr_q <= in_addr_q;
      end
      if (state_q == S_READ) begin
        core_line_q  <= seq_if.in_data;
        core_count_q <= index_q;
      end else begin
        core_line_q  <= core_line_q;
        core_count_q <= core_count_q;
      end
      core_start_q <= (state_d == S_ISSUE);
    end
  end

  // Output-RAM write port: one write per line, only during STORE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_we_q   <= 1'b0;
      out_addr_q <= {ADDR_W{1'b0}};
      out_data_q <= {WIDTH{1'b0}};
    end else begin
      out_we_q <= (state_d == S_STORE);
      if (state_d == S_STORE) begin
        out_addr_q <= index_q;
      end else begin
        out_addr_q <= out_addr_q;
      end
      if (state_q == S_WAIT && state_d == S_STORE) begin
        out_data_q <= timeout_hit_s ? {WIDTH{1'b0}} : seq_if.core_result;
      end else begin
        out_data_q <= out_data_q;
      end
    end
  end

  // Run status: progress count, busy/done flags and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lines_done_q  <= {(ADDR_W + 1){1'b0}};
      busy_q        <= 1'b0;
      all_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (start_run_s) begin
        lines_done_q <= {(ADDR_W + 1){1'b0}};
      end else if (state_q == S_STORE) begin
        lines_done_q <= lines_done_q + ONE_L;
      end else begin
        lines_done_q <= lines_done_q;
      end
      busy_q     <= (state_d != S_IDLE) && (state_d != S_FINISH);
      all_done_q <= (state_d == S_FINISH);
      if (start_run_s) begin
        timeout_err_q <= 1'b0;
      end else if (timeout_hit_s) begin
        timeout_err_q <= 1'b1;
      end else begin
        timeout_err_q <= timeout_err_q;
      end
    end
  end

  assign seq_if.in_addr     = in_addr_q;
  assign seq_if.core_start  = core_start_q;
  assign seq_if.core_line   = core_line_q;
  assign seq_if.core_count  = core_count_q;
  assign seq_if.out_we      = out_we_q;
  assign seq_if.out_addr    = out_addr_q;
  assign seq_if.out_data    = out_data_q;
  assign seq_if.busy        = busy_q;
  assign seq_if.all_done    = all_done_q;
  assign seq_if.timeout_err = timeout_err_q;
  assign seq_if.lines_done  = lines_done_q;

endmodule

// File: tb/tb_line_sequencer.sv
// Scoreboard bench for line_sequencer: expected writes are queued when a run
// is started, and a monitor pops and compares them on every out_we.
module tb_line_sequencer;
  localparam int LINES   = 64;
  localparam int WIDTH   = 25;
  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  line_sequencer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) seq_if ();

  line_sequencer #(
    .LINES(LINES), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seq_if(seq_if)
  );

  logic [WIDTH-1:0]        in_ram    [LINES];
  logic [WIDTH-1:0]        out_ram   [LINES];
  logic [WIDTH-1:0]        saved_ram [LINES];
  logic [ADDR_W+WIDTH-1:0] exp_q [$];
  int start_cyc [LINES];
  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_base = 0;
  int run_id = 0;
  int never_line = -1;
  int collide_line = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Input RAM (one-cycle read latency) and output RAM.
  initial forever begin
    @(posedge clk);
    seq_if.in_data <= in_ram[seq_if.in_addr];
    if (seq_if.out_we === 1'b1) out_ram[seq_if.out_addr] <= seq_if.out_data;
  end

  // Core model: done 3 cycles after start with result = ~line; line
  // never_line gets no done, line collide_line gets done exactly in the
  // WAIT cycle where the watchdog reads TIMEOUT (TIMEOUT+1 cycles after start).
  initial begin : core_model
    int d;
    logic [ADDR_W-1:0] ln;
    logic [WIDTH-1:0] res;
    seq_if.core_done   = 1'b0;
    seq_if.core_result = '0;
    forever begin
      @(negedge clk);
      if (seq_if.core_start === 1'b1) begin
        ln  = seq_if.core_count;
        res = ~seq_if.core_line;
        if (int'(ln) == never_line) d = 0;
        else if (int'(ln) == collide_line) d = TIMEOUT + 1;
        else d = 3;
        if (d != 0) begin
          repeat (d) @(negedge clk);
          seq_if.core_done   = 1'b1;
          seq_if.core_result = res;
          @(negedge clk);
          seq_if.core_done = 1'b0;
        end
      end
    end
  end

  // Monitor: start-pulse sequence and scoreboard of output writes.
  initial begin : monitor
    logic [ADDR_W+WIDTH-1:0] e;
    int exp_count;
    int seen_run;
    exp_count = 0;
    seen_run  = 0;
    forever begin
      @(negedge clk);
      if (seen_run != run_id) begin
        seen_run  = run_id;
        exp_count = 0;
      end
      if (seq_if.core_start === 1'b1) begin
        check("core_count", 32'(seq_if.core_count), 32'(exp_count));
        check("core_line", 32'(seq_if.core_line), 32'(in_ram[seq_if.core_count]));
        start_cyc[seq_if.core_count] = cyc;
        exp_count++;
      end
      if (seq_if.out_we === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(seq_if.out_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(seq_if.out_addr), 32'(e[ADDR_W+WIDTH-1:WIDTH]));
          check("wr_data", 32'(seq_if.out_data), 32'(e[WIDTH-1:0]));
        end
      end
    end
  end

  task automatic start_run(input int nev, input int col);
    logic [WIDTH-1:0] d;
    never_line   = nev;
    collide_line = col;
    run_id++;
    wr_base = wr_cnt;
    for (int i = 0; i < LINES; i++) begin
      d = WIDTH'(~(i * 32'h10001));
      if (i == nev) d = '0;
      exp_q.push_back({ADDR_W'(i), d});
    end
    seq_if.go = 1'b1;
    @(negedge clk);
    seq_if.go = 1'b0;
  endtask

  task automatic wait_start(input int line);
    int n = 0;
    while (!(seq_if.core_start === 1'b1 && int'(seq_if.core_count) == line) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("wait_start", 32'(n < 4000), 32'd1);
  endtask

  task automatic finish_checks(input string name, input logic exp_to);
    int n = 0;
    while (seq_if.all_done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_all_done"}, 32'(seq_if.all_done), 32'd1);
    check({name, "_lines_done"}, 32'(seq_if.lines_done), 32'd64);
    check({name, "_timeout_err"}, 32'(seq_if.timeout_err), 32'(exp_to));
    check({name, "_busy"}, 32'(seq_if.busy), 32'd0);
    check({name, "_writes"}, 32'(wr_cnt - wr_base), 32'd64);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic compare_saved(input string name);
    int diffs = 0;
    for (int i = 0; i < LINES; i++) if (out_ram[i] !== saved_ram[i]) diffs++;
    check(name, 32'(diffs), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_in_addr"}, 32'(seq_if.in_addr), 32'd0);
    check({name, "_core_line"}, 32'(seq_if.core_line), 32'd0);
    check({name, "_core_count"}, 32'(seq_if.core_count), 32'd0);
    check({name, "_core_start"}, 32'(seq_if.core_start), 32'd0);
    check({name, "_out_we"}, 32'(seq_if.out_we), 32'd0);
    check({name, "_out_addr"}, 32'(seq_if.out_addr), 32'd0);
    check({name, "_out_data"}, 32'(seq_if.out_data), 32'd0);
    check({name, "_lines_done"}, 32'(seq_if.lines_done), 32'd0);
    check({name, "_busy"}, 32'(seq_if.busy), 32'd0);
    check({name, "_all_done"}, 32'(seq_if.all_done), 32'd0);
    check({name, "_timeout_err"}, 32'(seq_if.timeout_err), 32'd0);
  endtask

  // Directed stimulus sequence.
  initial begin : main
    int n;
    for (int i = 0; i < LINES; i++) begin
      in_ram[i]  = WIDTH'(i * 32'h10001);
      out_ram[i] = '0;
    end
    seq_if.go = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Run 1: normal run from IDLE, with go-to-first-start latency.
    start_run(-1, -1);
    n = 1;
    while (seq_if.core_start !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("go_to_start_edges", 32'(n), 32'd3);
    finish_checks("run1", 1'b0);
    for (int i = 0; i < LINES; i++) saved_ram[i] = out_ram[i];
    check("normal_line_period", 32'(start_cyc[4] - start_cyc[3]), 32'd7);

    // Run 2: from FINISH; go pulsed while line 10 is in flight is ignored.
    start_run(-1, -1);
    check("restart_all_done", 32'(seq_if.all_done), 32'd0);
    check("restart_busy", 32'(seq_if.busy), 32'd1);
    wait_start(10);
    seq_if.go = 1'b1;
    @(negedge clk);
    seq_if.go = 1'b0;
    finish_checks("run2", 1'b0);
    compare_saved("run2_ram_identical");

    // Run 3: line 5 never completes; WAIT lasts TIMEOUT+1 cycles,
    // so its start and the next one are TIMEOUT+5 cycles apart.
    start_run(5, -1);
    finish_checks("run3", 1'b1);
    check("timeout_start_gap", 32'(start_cyc[6] - start_cyc[5]), 32'(TIMEOUT + 5));

    // Run 4: done arrives in the watchdog's expiry cycle on line 2.
    start_run(-1, 2);
    finish_checks("run4", 1'b0);

    // Run 5: reset two cycles after line 20 starts aborts the run.
    start_run(-1, -1);
    wait_start(20);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("abort");
    check("abort_pending", 32'(exp_q.size()), 32'd44);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("abort_writes", 32'(wr_cnt - wr_base), 32'd20);
    rst = 1'b1;
    @(negedge clk);

    // Run 6: restart after the abort begins at address 0.
    start_run(-1, -1);
    check("restart_in_addr", 32'(seq_if.in_addr), 32'd0);
    check("restart_busy_after_reset", 32'(seq_if.busy), 32'd1);
    finish_checks("run6", 1'b0);
    compare_saved("run6_ram_identical");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
